// File: rtl/mtl_pixel_prefetch_if.sv
// Avalon-MM pipelined read port between the pixel prefetch buffer (master)
// and the SDRAM controller (slave).
interface mtl_pixel_prefetch_if #(
   parameter int AW = 24
);
   logic          oMEM_READ;
   logic [AW-1:0] oMEM_ADDR;
   logic          iMEM_WAITREQ;
   logic          iMEM_READDATAVALID;
   logic [31:0]   iMEM_READDATA;

   modport master (
      output oMEM_READ,
      output oMEM_ADDR,
      input  iMEM_WAITREQ,
      input  iMEM_READDATAVALID,
      input  iMEM_READDATA
   );

   modport slave (
      input  oMEM_READ,
      input  oMEM_ADDR,
      output iMEM_WAITREQ,
      output iMEM_READDATAVALID,
      output iMEM_READDATA
   );
endinterface

// File: rtl/mtl_pixel_prefetch.sv
// Show-ahead pixel prefetch FIFO: streams one frame of words from SDRAM and
// hands them to the MTL LCD controller, restarting on every new frame.
module mtl_pixel_prefetch #(
   parameter int          DEPTH           = 64,
   parameter int          FRAME_WORDS     = 384000,
   parameter int          AW              = 24,
   parameter logic [31:0] UNDERFLOW_COLOR = 32'h00FF00FF
) (
   input  logic                        CLK_33,
   input  logic                        reset,
   input  logic                        iNewFrame,
   input  logic [AW-1:0]               iBASE_ADDR,
   input  logic                        iRD_EN,
   output logic [31:0]                 oREAD_DATA,
   mtl_pixel_prefetch_if.master        mem,
   output logic [$clog2(DEPTH):0]      oLEVEL,
   output logic [15:0]                 oUNDERFLOW_CNT
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam int IW = $clog2(FRAME_WORDS + 1);
   localparam logic [LW:0]   DEPTH_W    = (LW+1)'(DEPTH);
   localparam logic [IW-1:0] FRAME_W    = IW'(FRAME_WORDS);
   localparam logic [IW-1:0] FRAME_LAST = IW'(FRAME_WORDS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DONE} state_t;
   state_t state_reg, state_next;

   logic [PW-1:0] head_reg, tail_reg;
   logic [LW-1:0] level_reg, outstanding_reg, discard_reg;
   logic [IW-1:0] issued_reg;
   logic [AW-1:0] addr_reg, frame_addr_reg;
   logic          hold_reg, stale_reg;
   logic [15:0]   ucnt_reg;
   logic [31:0]   mem_data [DEPTH];

   logic          can_issue, mem_read, stall, accept, accept_stale, accept_new;
   logic          ret, wr_en, pop, underflow;
   logic [LW-1:0] outstanding_upd;

   always_comb begin
      can_issue = (state_reg == ST_FETCH)
               && (({1'b0, level_reg} + {1'b0, outstanding_reg}) < DEPTH_W)
               && (issued_reg < FRAME_W)
               && (discard_reg == '0);
      // A request stalled by waitrequest stays up regardless of fill level.
      mem_read     = hold_reg | can_issue;
      stall        = mem_read & mem.iMEM_WAITREQ;
      accept       = mem_read & ~mem.iMEM_WAITREQ;
      accept_stale = accept & stale_reg;
      accept_new   = accept & ~stale_reg;
      // Stray returns with nothing outstanding (e.g. straight after reset) are ignored.
      ret          = mem.iMEM_READDATAVALID & (outstanding_reg != '0);
      wr_en        = ret & (discard_reg == '0) & ~iNewFrame;
      pop          = iRD_EN & ~iNewFrame & (level_reg != '0);
      underflow    = iRD_EN & ~iNewFrame & (level_reg == '0);
      outstanding_upd = outstanding_reg + LW'(accept) - LW'(ret);
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (iNewFrame) state_next = ST_FETCH;
         ST_FETCH: begin
            if (iNewFrame)
               state_next = ST_FETCH;
            else if (accept_new && issued_reg == FRAME_LAST)
               state_next = ST_DONE;
         end
         ST_DONE:  if (iNewFrame) state_next = ST_FETCH;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK_33) begin
      if (reset) begin
         state_reg       <= ST_IDLE;
         head_reg        <= '0;
         tail_reg        <= '0;
         level_reg       <= '0;
         outstanding_reg <= '0;
         discard_reg     <= '0;
         issued_reg      <= '0;
         addr_reg        <= '0;
         frame_addr_reg  <= '0;
         hold_reg        <= 1'b0;
         stale_reg       <= 1'b0;
         ucnt_reg        <= '0;
      end else begin
         state_reg       <= state_next;
         hold_reg        <= stall;
         outstanding_reg <= outstanding_upd;

         if (underflow && ucnt_reg != 16'hFFFF)
            ucnt_reg <= ucnt_reg + 16'd1;

         if (iNewFrame) begin
            head_reg    <= '0;
            tail_reg    <= '0;
            level_reg   <= '0;
            issued_reg  <= '0;
            discard_reg <= outstanding_upd;
            // A stalled old-frame request keeps its address; the new base waits.
            if (stall) begin
               frame_addr_reg <= iBASE_ADDR;
               stale_reg      <= 1'b1;
            end else begin
               addr_reg  <= iBASE_ADDR;
               stale_reg <= 1'b0;
            end
         end else begin
            if (pop)
               head_reg <= head_reg + PW'(1);
            if (wr_en)
               tail_reg <= tail_reg + PW'(1);
            level_reg   <= level_reg + LW'(wr_en) - LW'(pop);
            discard_reg <= discard_reg + LW'(accept_stale)
                         - LW'(ret && discard_reg != '0);
            if (accept_new)
               issued_reg <= issued_reg + IW'(1);
            if (accept_stale) begin
               addr_reg  <= frame_addr_reg;
               stale_reg <= 1'b0;
            end else if (accept_new) begin
               addr_reg <= addr_reg + AW'(1);
            end
         end
      end
   end

   always_ff @(posedge CLK_33) begin
      if (wr_en)
         mem_data[tail_reg] <= mem.iMEM_READDATA;
   end

   assign mem.oMEM_READ  = mem_read;
   assign mem.oMEM_ADDR  = addr_reg;
   assign oLEVEL         = level_reg;
   assign oUNDERFLOW_CNT = ucnt_reg;
   assign oREAD_DATA     = (level_reg == '0) ? UNDERFLOW_COLOR : mem_data[head_reg];
endmodule
